// File: rtl/dsp_wb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_wb_master_if
//  Description : Wishbone B3 classic bus bundle between the DSP file engine's
//                bus master and RAM0.
//                master modport : drives adr/dat_o/sel/we/cyc/stb,
//                                 receives dat_i/ack/err
//                slave modport  : the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface dsp_wb_master_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/dsp_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_wb_master
//  Description : Wishbone B3 classic single-transfer master for the DSP file
//                state machine. Turns one request (start/address/selection/
//                write/data_wr) into one Wishbone cycle, with an ack timeout
//                and a saturating error counter so a dead or erroring slave
//                cannot hang the requester.
//  Ports       : wb_clk, wb_rst_n (sync, active-low)
//                request side : start, address, selection, write, data_wr
//                               -> active, data_rd, bus_error, error_count
//                bus side     : wb (dsp_wb_master_if.master)
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_wb_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 255     // 1..65535 BUS cycles before forced end
) (
    input  wire logic          wb_clk,
    input  wire logic          wb_rst_n,

    input  wire logic          start,
    input  wire logic [aw-1:0] address,
    input  wire logic [3:0]    selection,
    input  wire logic          write,
    input  wire logic [dw-1:0] data_wr,
    output logic               active,
    output logic [dw-1:0]      data_rd,
    output logic               bus_error,
    output logic [7:0]         error_count,

    dsp_wb_master_if.master    wb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Timer value seen during the last permitted BUS cycle.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] timer;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            active      <= 1'b0;
            data_rd     <= '0;
            bus_error   <= 1'b0;
            error_count <= '0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
        end else begin
            bus_error <= 1'b0;   // single-cycle pulse

            case (state)
                IDLE: begin
                    if (start) begin
                        wb.wb_adr_o <= address;
                        wb.wb_sel_o <= selection;
                        wb.wb_we_o  <= write;
                        wb.wb_dat_o <= data_wr;
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        active      <= 1'b1;
                        timer       <= '0;
                        state       <= BUS;
                    end
                end

                BUS: begin
                    timer <= timer + 16'd1;
                    // Error beats ack; ack beats the timeout on the final cycle.
                    if (wb.wb_err_i || (!wb.wb_ack_i && (timer == TIMER_LAST))) begin
                        data_rd     <= '0;
                        bus_error   <= 1'b1;
                        if (error_count != 8'hFF) begin
                            error_count <= error_count + 8'd1;
                        end
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_dat_o <= '0;
                        active      <= 1'b0;
                        state       <= RELEASE;
                    end else if (wb.wb_ack_i) begin
                        if (!wb.wb_we_o) begin
                            data_rd <= wb.wb_dat_i;
                        end
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_dat_o <= '0;
                        active      <= 1'b0;
                        state       <= RELEASE;
                    end
                end

                // Wait for the requester to drop a start it may still hold,
                // otherwise the same request would be issued twice.
                RELEASE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_wb_master
//  Description : Directed bench for dsp_wb_master (TIMEOUT = 8): zero-wait
//                read, waited write, held start, timeout, err+ack, error
//                counter saturation and reset during a transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_wb_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic        active;
    logic [31:0] data_rd;
    logic        bus_error;
    logic [7:0]  error_count;

    int tests;
    int fails;

    dsp_wb_master_if #(.dw(32), .aw(32)) bus ();

    dsp_wb_master #(.dw(32), .aw(32), .TIMEOUT(8)) dut (
        .wb_clk      (clk),
        .wb_rst_n    (rst_n),
        .start       (start),
        .address     (address),
        .selection   (selection),
        .write       (write),
        .data_wr     (data_wr),
        .active      (active),
        .data_rd     (data_rd),
        .bus_error   (bus_error),
        .error_count (error_count),
        .wb          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer terminated by wb_err_i, ending back in IDLE.
    task automatic err_transfer();
        start = 1'b1; address = 32'h80; write = 1'b0;
        tick();
        start = 1'b0; bus.wb_err_i = 1'b1;
        tick();
        bus.wb_err_i = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; start = 1'b0; address = '0; selection = '0;
        write = 1'b0; data_wr = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

        // ---------------- reset ----------------
        tick(); tick();
        check("rst_cyc",    32'(bus.wb_cyc_o), 32'd0);
        check("rst_active", 32'(active),       32'd0);
        check("rst_adr",    bus.wb_adr_o,      32'd0);
        check("rst_errcnt", 32'(error_count),  32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- zero-wait read ----------------
        start = 1'b1; address = 32'h20; selection = 4'hF; write = 1'b0;
        tick();
        check("rd_cyc",    32'(bus.wb_cyc_o), 32'd1);
        check("rd_stb",    32'(bus.wb_stb_o), 32'd1);
        check("rd_active", 32'(active),       32'd1);
        check("rd_adr",    bus.wb_adr_o,      32'h20);
        check("rd_sel",    32'(bus.wb_sel_o), 32'hF);
        check("rd_we",     32'(bus.wb_we_o),  32'd0);
        start = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h12345678;
        tick();
        check("rd_cyc_end",    32'(bus.wb_cyc_o), 32'd0);
        check("rd_active_end", 32'(active),       32'd0);
        check("rd_data",       data_rd,           32'h12345678);
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
        tick();

        // ---------------- write, 3 wait states ----------------
        start = 1'b1; address = 32'h2C; data_wr = 32'h0000AB00;
        selection = 4'h2; write = 1'b1;
        tick();
        start = 1'b0; data_wr = 32'hFFFFFFFF; address = 32'h0; selection = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("wr_we",  32'(bus.wb_we_o),  32'd1);
            check("wr_sel", 32'(bus.wb_sel_o), 32'h2);
            check("wr_dat", bus.wb_dat_o,      32'h0000AB00);
            check("wr_cyc", 32'(bus.wb_cyc_o), 32'd1);
            if (i == 3) bus.wb_ack_i = 1'b1;
            tick();
        end
        bus.wb_ack_i = 1'b0;
        check("wr_cyc_end", 32'(bus.wb_cyc_o), 32'd0);
        check("wr_we_end",  32'(bus.wb_we_o),  32'd0);
        check("wr_dat_clr", bus.wb_dat_o,      32'd0);
        check("wr_adr_keep", bus.wb_adr_o,     32'h2C);
        check("wr_sel_keep", 32'(bus.wb_sel_o), 32'h2);
        check("wr_data_rd", data_rd,           32'h12345678);
        check("wr_buserr",  32'(bus_error),    32'd0);
        tick();

        // ---------------- start held after completion ----------------
        start = 1'b1; address = 32'h40; write = 1'b0; selection = 4'hF;
        tick();
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFEF00D;
        tick();
        bus.wb_ack_i = 1'b0;
        check("hold_data", data_rd, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_no_cyc",    32'(bus.wb_cyc_o), 32'd0);
            check("hold_no_active", 32'(active),       32'd0);
        end
        start = 1'b0;
        tick();
        check("hold_idle_cyc", 32'(bus.wb_cyc_o), 32'd0);

        // ---------------- timeout (8 BUS cycles) ----------------
        start = 1'b1; address = 32'h50; write = 1'b0;
        tick();
        start = 1'b0;
        check("to_cyc0", 32'(bus.wb_cyc_o), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_cyc_hold", 32'(bus.wb_cyc_o), 32'd1);
            check("to_no_err",   32'(bus_error),    32'd0);
        end
        tick();
        check("to_cyc_end", 32'(bus.wb_cyc_o), 32'd0);
        check("to_buserr",  32'(bus_error),    32'd1);
        check("to_data",    data_rd,           32'd0);
        check("to_errcnt",  32'(error_count),  32'd1);
        tick();
        check("to_pulse_once", 32'(bus_error), 32'd0);

        // ---------------- err together with ack ----------------
        start = 1'b1; address = 32'h60; write = 1'b0;
        tick();
        start = 1'b0; bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h11111111;
        tick();
        bus.wb_err_i = 1'b0; bus.wb_ack_i = 1'b0;
        check("ea_data",   data_rd,          32'd0);
        check("ea_buserr", 32'(bus_error),   32'd1);
        check("ea_errcnt", 32'(error_count), 32'd2);
        check("ea_cyc",    32'(bus.wb_cyc_o), 32'd0);
        tick();

        // ---------------- saturation ----------------
        for (int i = 0; i < 253; i++) err_transfer();
        check("sat_255", 32'(error_count), 32'hFF);
        for (int i = 0; i < 5; i++) err_transfer();
        check("sat_hold", 32'(error_count), 32'hFF);

        // ---------------- reset mid-transfer ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("r2_errcnt", 32'(error_count), 32'd0);
        start = 1'b1; address = 32'h70; data_wr = 32'hDEADBEEF;
        selection = 4'hF; write = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mr_cyc_busy", 32'(bus.wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mr_cyc",    32'(bus.wb_cyc_o), 32'd0);
        check("mr_stb",    32'(bus.wb_stb_o), 32'd0);
        check("mr_active", 32'(active),       32'd0);
        check("mr_adr",    bus.wb_adr_o,      32'd0);
        check("mr_dat",    bus.wb_dat_o,      32'd0);
        check("mr_we",     32'(bus.wb_we_o),  32'd0);
        check("mr_errcnt", 32'(error_count),  32'd0);
        check("mr_buserr", 32'(bus_error),    32'd0);
        rst_n = 1'b1;
        tick();
        start = 1'b1; address = 32'h24; write = 1'b0;
        tick();
        check("pr_active", 32'(active), 32'd1);
        start = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BADF00D;
        tick();
        bus.wb_ack_i = 1'b0;
        check("pr_data",   data_rd,          32'h0BADF00D);
        check("pr_errcnt", 32'(error_count), 32'd0);
        check("pr_buserr", 32'(bus_error),   32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_wb_master.md
# dsp_wb_master

Wishbone B3 classic single-transfer bus master sitting directly downstream of the DSP file state machine. It accepts one request at a time on the simple request interface (`start`/`address`/`selection`/`write`/`data_wr` in, `active`/`data_rd` out) and turns it into one Wishbone cycle toward RAM0. It also enforces an ack timeout and reports bus errors, so a missing or erroring slave cannot hang the file engine.

## Interface
- `dw`, 32, data width.
- `aw`, 32, address width.
- `TIMEOUT`, 255, cycles waited for `wb_ack_i`/`wb_err_i` before forced termination; legal range 1–65535.

Ports:
- `wb_clk` in 1: single clock; all logic on its rising edge.
- `wb_rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request strobe; held high by the requester until it sees `active`.
- `address` in aw: byte address of the request.
- `selection` in 4: byte lane enables.
- `write` in 1: 1 = write, 0 = read.
- `data_wr` in dw: write data, lane-aligned.
- `active` out 1: a transfer is accepted and in flight.
- `data_rd` out dw: read data; valid from the cycle `active` falls until the next accept.
- `bus_error` out 1: one-cycle pulse when a transfer ends by `wb_err_i` or by timeout.
- `error_count` out 8: saturating count of errored transfers.
- `wb_adr_o` out aw: Wishbone address.
- `wb_dat_o` out dw: Wishbone write data.
- `wb_sel_o` out 4: Wishbone byte select.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_dat_i` in dw: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.

## Operation
- Reset value of every output is 0. The state machine resets to IDLE and the timeout counter resets to 0.
- **IDLE**
  - On `start`=1: register `address`, `selection`, `write` and `data_wr` onto `wb_adr_o`/`wb_sel_o`/`wb_we_o`/`wb_dat_o`.
  - Set `wb_cyc_o`=`wb_stb_o`=1 and `active`=1, clear the timeout counter, then go to BUS.
- **BUS**
  - Hold all Wishbone outputs stable. Increment the timeout counter each cycle.
  - `wb_ack_i`=1: if the request is a read, `data_rd`<=`wb_dat_i`. Drop `cyc`/`stb`/`we`, set `active`=0, go to RELEASE.
  - `wb_err_i`=1, or counter reaches `TIMEOUT`-1 without ack: `data_rd`<=0, pulse `bus_error`, increment `error_count` (saturates at 8'hFF). Drop `cyc`/`stb`/`we`, set `active`=0, go to RELEASE.
  - `wb_ack_i` and `wb_err_i` in the same cycle: error wins.
  - Writes leave `data_rd` unchanged.
- **RELEASE**
  - Stay while `start`=1. This prevents re-accepting a request the requester is still holding.
  - On `start`=0, go to IDLE.
- `wb_dat_o` is cleared to 0 when the transfer ends. `wb_adr_o` and `wb_sel_o` keep their last values.
- Inputs on the request interface are sampled only in IDLE. Changes during BUS or RELEASE are ignored.
- Reset asserted mid-transfer: on the next edge `wb_cyc_o`/`wb_stb_o` drop and every output returns to 0. No error is counted and the state returns to IDLE.

## Timing
- Accept latency: `start` seen high at edge N gives `wb_cyc_o`/`wb_stb_o`/`active` high after edge N.
- Ack at edge M gives `active`=0 and `data_rd` valid after edge M. Minimum `active` width is 1 cycle (ack on the first BUS cycle).
- Timeout: with no ack, the cycle is terminated after exactly `TIMEOUT` BUS cycles.
- Back-to-back throughput: one transfer every 3 cycles minimum (IDLE, BUS, RELEASE), provided `start` drops 1 cycle after `active` rises.
- No combinational path from any input to any output.

## Test plan
- Read, zero-wait slave:
  - Stimulus: `start` with `address`=0x20, `selection`=F, ack on the first BUS cycle, `wb_dat_i`=0x12345678.
  - Response: `cyc` high exactly 1 cycle, `active` high 1 cycle, then `data_rd`=0x12345678.
- Write with 3 wait states:
  - Stimulus: `address`=0x2C, `data_wr`=0x0000AB00, `selection`=2.
  - Response: `wb_we_o`=1, `wb_sel_o`=2, `wb_dat_o`=0x0000AB00 held stable for 4 cycles. `data_rd` unchanged, `bus_error`=0.
- Start held: requester holds `start` high 4 cycles after `active` falls -> exactly one Wishbone cycle issued; state stays RELEASE until `start`=0.
- Timeout and error:
  - Stimulus: `TIMEOUT`=8 and no ack.
  - Response: `cyc` drops after 8 cycles, `bus_error` pulses once, `data_rd`=0, `error_count`=1.
  - Then `wb_err_i` together with `wb_ack_i` -> error path taken, `error_count`=2.
- Saturation: 260 consecutive erroring transfers -> `error_count` stops at 0xFF.
- Reset mid-transfer: `wb_rst_n`=0 during BUS -> all outputs 0 on the next edge. A subsequent read completes normally with `error_count` still 0.
